// File: rtl/nibble_parity_pkg.sv
// Shared encodings for the nibble parity receiver: FSM states and parity modes.
package nibble_parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    localparam int   DATA_BITS = 4;

endpackage

// File: rtl/nibble_parity_rx_xor4.sv
// Four-input XOR reduction used as the reference parity of the data nibble.
module parity_xor4 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e
);

    assign e = a ^ b ^ c ^ d;

endmodule

// File: rtl/nibble_parity_rx.sv
// Serial receiver for start + 4 data + parity + stop frames, qualified by bit_valid,
// with per-frame parity/framing flags and a saturating error counter.
module nibble_parity_rx #(
    parameter int   ERR_W       = 8,
    parameter logic ODD_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             mode_odd,
    output logic [3:0]       nib,
    output logic             nib_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);
    import nibble_parity_pkg::*;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [1:0]       LAST_BIT = 2'(DATA_BITS - 1);

    state_t     r_state;
    state_t     w_next;
    logic       w_start;
    logic       w_shift;
    logic       w_par;
    logic       w_stop;
    logic       w_perr;
    logic       w_ferr;
    logic       w_xor4;
    logic [1:0] r_cnt;
    logic       r_acc;
    logic       r_mode;
    logic       r_pbit;
    logic [3:0] r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_shift = 1'b0;
        w_par   = 1'b0;
        w_stop  = 1'b0;
        busy    = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (bit_valid && !bit_in) begin
                    w_start = 1'b1;
                    w_next  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_valid) begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_BIT) w_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bit_valid) begin
                    w_par  = 1'b1;
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Any stop value ends the frame; a 0 here is never a new start bit.
                if (bit_valid) begin
                    w_stop = 1'b1;
                    w_next = ST_IDLE;
                end
            end
        endcase
    end

    // By STOP the accumulator holds a^b^c^d^p, so it directly encodes the parity result.
    assign w_perr = (r_acc != r_mode);
    assign w_ferr = ~bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= 1'b0;
            r_mode     <= ODD_DEFAULT;
            r_pbit     <= 1'b0;
            r_shift    <= '0;
            nib        <= '0;
            nib_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            nib_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (w_start) begin
                r_mode <= mode_odd;
                r_cnt  <= '0;
                r_acc  <= 1'b0;
            end
            if (w_shift) begin
                r_shift <= {r_shift[2:0], bit_in};
                r_acc   <= r_acc ^ bit_in;
                r_cnt   <= r_cnt + 2'd1;
            end
            if (w_par) begin
                r_acc  <= r_acc ^ bit_in;
                r_pbit <= bit_in;
            end
            if (w_stop) begin
                nib        <= r_shift;
                nib_valid  <= 1'b1;
                parity_err <= w_perr;
                frame_err  <= w_ferr;
                if ((w_perr || w_ferr) && (err_count != ERR_MAX))
                    err_count <= err_count + ERR_W'(1);
            end
        end
    end

    parity_xor4 u_xor4 (
        .a (r_shift[3]),
        .b (r_shift[2]),
        .c (r_shift[1]),
        .d (r_shift[0]),
        .e (w_xor4)
    );

`ifndef SYNTHESIS
    a_acc_matches_xor4: assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_STOP) |-> (r_acc == (w_xor4 ^ r_pbit)));
`endif

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Scoreboarded bench for nibble_parity_rx: default instance plus a 2-bit counter instance.
module tb_nibble_parity_rx;

    typedef struct packed {
        logic [3:0] nib;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       mode_odd;
    logic [3:0] nib;
    logic       nib_valid;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;
    logic [3:0] nib2;
    logic       nib_valid2;
    logic       parity_err2;
    logic       frame_err2;
    logic [1:0] err_count2;
    logic       busy2;

    exp_t       sb_q[$];
    exp_t       mon_got;
    exp_t       mon_exp;
    int         n_cmp;
    int         n_fail;
    int         n_pulse;
    logic [7:0] exp_cnt;
    logic [1:0] exp_cnt2;

    nibble_parity_rx dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .mode_odd(mode_odd),
        .nib(nib), .nib_valid(nib_valid), .parity_err(parity_err), .frame_err(frame_err),
        .err_count(err_count), .busy(busy)
    );

    nibble_parity_rx #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .mode_odd(mode_odd),
        .nib(nib2), .nib_valid(nib_valid2), .parity_err(parity_err2), .frame_err(frame_err2),
        .err_count(err_count2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst && nib_valid) begin
            n_pulse++;
            n_cmp++;
            mon_got = '{nib: nib, perr: parity_err, ferr: frame_err};
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_nib_valid: got nib=%b perr=%b ferr=%b, none pending",
                         nib, parity_err, frame_err);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL frame_output: got nib=%b perr=%b ferr=%b, want nib=%b perr=%b ferr=%b",
                             mon_got.nib, mon_got.perr, mon_got.ferr,
                             mon_exp.nib, mon_exp.perr, mon_exp.ferr);
                end
            end
        end
    end

    task automatic idle(input int n);
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Data line toggles randomly during gaps; bit_valid low must mask it.
    task automatic send_bit(input logic b, input int gap);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic mode, input logic [3:0] d, input logic p,
                              input logic stop, input int gap, input logic flip);
        exp_t e;
        e.nib  = d;
        e.perr = ((^d) ^ p) != mode;
        e.ferr = ~stop;
        sb_q.push_back(e);
        if (e.perr || e.ferr) begin
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
        end
        mode_odd = mode;
        send_bit(1'b0, gap);
        if (flip) mode_odd = ~mode;
        for (int i = 3; i >= 0; i--) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(stop, gap);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_cnt  = '0;
        exp_cnt2 = '0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b0;
        mode_odd  = 1'b0;
        #2;
        n_cmp++;
        if ({nib, nib_valid, parity_err, frame_err, err_count, busy} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nib=%b nv=%b pe=%b fe=%b cnt=%0d busy=%b, want all 0",
                     nib, nib_valid, parity_err, frame_err, err_count, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (err_count2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt2: got %0d want 0", err_count2);
        end
    endtask

    task automatic test_even();
        int p0;
        p0 = n_pulse;
        // Parity bit chosen so data 1011 carries even parity.
        send_frame(1'b0, 4'b1011, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        n_cmp++;
        if (n_pulse - p0 !== 1) begin
            n_fail++;
            $display("FAIL even_pulses: got %0d want 1", n_pulse - p0);
        end
        n_cmp++;
        if (err_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL even_cnt: got %0d want %0d", err_count, exp_cnt);
        end
        n_cmp++;
        if (nib !== 4'b1011) begin
            n_fail++;
            $display("FAIL nib_hold: got %b want 1011", nib);
        end
    endtask

    task automatic test_odd();
        send_frame(1'b1, 4'b1100, 1'b1, 1'b1, 0, 1'b0);
        idle(1);
        send_frame(1'b1, 4'b1100, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        n_cmp++;
        if (err_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL odd_cnt: got %0d want %0d", err_count, exp_cnt);
        end
    endtask

    task automatic test_frame_err();
        send_frame(1'b0, 4'b0001, 1'b1, 1'b0, 0, 1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop0_not_start: got busy=%b want 0", busy);
        end
        n_cmp++;
        if (err_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL ferr_cnt: got %0d want %0d", err_count, exp_cnt);
        end
    endtask

    task automatic test_mode_hold();
        send_frame(1'b1, 4'b1010, 1'b1, 1'b1, 0, 1'b1);
        send_frame(1'b0, 4'b0111, 1'b1, 1'b1, 0, 1'b1);
        idle(2);
        n_cmp++;
        if (err_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL mode_hold_cnt: got %0d want %0d", err_count, exp_cnt);
        end
    endtask

    task automatic test_gaps();
        int p0;
        p0 = n_pulse;
        send_frame(1'b0, 4'b1011, 1'b1, 1'b1, 3, 1'b0);
        idle(2);
        n_cmp++;
        if (n_pulse - p0 !== 1) begin
            n_fail++;
            $display("FAIL gap_pulses: got %0d want 1", n_pulse - p0);
        end
        n_cmp++;
        if (nib !== 4'b1011) begin
            n_fail++;
            $display("FAIL gap_nib: got %b want 1011", nib);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = n_pulse;
        send_frame(1'b0, 4'b0110, 1'b0, 1'b1, 0, 1'b0);
        send_frame(1'b1, 4'b1001, 1'b0, 1'b0, 0, 1'b0);
        send_frame(1'b0, 4'b1111, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        n_cmp++;
        if (n_pulse - p0 !== 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d want 3", n_pulse - p0);
        end
        n_cmp++;
        if (err_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_cnt: got %0d want %0d", err_count, exp_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int p0;
        mode_odd = 1'b0;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst = 1'b1;
        #2;
        n_cmp++;
        if (busy !== 1'b0 || nib !== 4'b0000 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b nib=%b cnt=%0d want 0/0000/0", busy, nib, err_count);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_cnt  = '0;
        exp_cnt2 = '0;
        p0 = n_pulse;
        send_frame(1'b0, 4'b0101, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        n_cmp++;
        if (n_pulse - p0 !== 1) begin
            n_fail++;
            $display("FAIL midreset_pulses: got %0d want 1", n_pulse - p0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_frame(1'b0, 4'b0000, 1'b1, 1'b1, 0, 1'b0);
            idle(1);
            n_cmp++;
            if (err_count2 !== exp_cnt2) begin
                n_fail++;
                $display("FAIL sat_cnt2[%0d]: got %0d want %0d", k, err_count2, exp_cnt2);
            end
            n_cmp++;
            if (err_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL sat_cnt8[%0d]: got %0d want %0d", k, err_count, exp_cnt);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        n_pulse  = 0;
        exp_cnt  = '0;
        exp_cnt2 = '0;
        test_reset();
        test_even();
        test_odd();
        test_frame_err();
        test_mode_hold();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        idle(3);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d frames still pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
